sipo_framed: RTL and testbench
==============================

Name: sipo_framed

Overview:
Parametrised serial-in/parallel-out deserialiser. It is the successor to the team's fixed 8-bit SIPO.
- Adds configurable word width and shift order.
- Adds a qualified bit strobe, a frame-resync input, and a registered parallel word with a one-cycle valid pulse.
- Sits between a serial line receiver and word-oriented downstream logic.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].
- CW, $clog2(WIDTH+1), width of bit_count. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial data; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies data_in this cycle.
- start  input  1  frame resync; discards any partial word.
- data_out  output  WIDTH  last completed word; held until the next word completes.
- word_valid  output  1  one-cycle pulse; data_out was updated this cycle.
- bit_count  output  CW  number of bits accepted into the current partial word.
- busy  output  1  high when bit_count != 0 (or a parity bit is pending).
- parity_err  output  1  parity result, qualified by word_valid (see Optional Feature).

Behaviour:
- All state changes occur on the rising edge of clk. Only one clock exists.
- Reset (reset=1 at an edge) clears: shift register 0, data_out 0, word_valid 0, bit_count 0, busy 0, parity_err 0.
- Reset has priority over start and bit_valid, including mid-word. The partial word is lost and no word_valid is produced.
- States:
  - IDLE: bit_count = 0.
  - SHIFT: 0 < bit_count < WIDTH.
  - PAR: only when parity is compiled in.
- Transitions:
  - IDLE -> SHIFT on an accepted bit.
  - SHIFT -> IDLE after the WIDTH-th bit, or -> PAR when parity is compiled in.
  - PAR -> IDLE on the parity bit.
- Bit acceptance is bit_valid=1. Cycles with bit_valid=0 hold all state, so gaps of any length between bits are allowed.
- Shift order:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - After WIDTH bits, the first bit received sits at the position given by MSB_FIRST.
- Word completion (final bit accepted at edge N):
  - At edge N, data_out is loaded with the completed word, including the final bit.
  - word_valid is 1 for exactly the cycle following edge N.
  - bit_count returns to 0.
  - Latency from the final bit's sampling edge to a visible word is 0 edges, i.e. same edge.
- Back-to-back words are supported with no idle cycle. A bit accepted in the word_valid cycle is bit 1 of the next word.
- start=1 clears the shift register and sets bit_count=0. No word_valid is produced for the discarded partial word, and data_out is unchanged.
- start=1 together with bit_valid=1: the partial word is discarded, and the bit is accepted as bit 1 of the new word (bit_count becomes 1).
- start=1 on the cycle the final bit arrives: start wins. No word is produced, and the bit begins the new word.
- bit_count never exceeds WIDTH-1 as visible output; it wraps to 0 on completion.
- data_in is ignored when bit_valid=0; X on data_in in those cycles must not propagate.

Optional Feature:
- Macro: SIPO_FRAMED_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one more accepted bit is taken as the parity bit (state PAR). busy stays 1.
  - word_valid and the data_out update occur on the parity bit's edge, not the last data bit's.
  - Parity is even: parity_err = XOR of all data bits XOR the parity bit.
  - parity_err is registered with data_out and is meaningful only when word_valid=1.
  - start or reset during PAR discards the word.
- Not defined:
  - No PAR state; completion occurs on the WIDTH-th bit.
  - parity_err is tied to 0.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, reset 2 cycles, then bits 1,0,1,1,1,0,1,0 on consecutive cycles -> data_out=8'hBA, word_valid high for exactly 1 cycle, bit_count 1..7 then 0.
2. Same bits with MSB_FIRST=0 and 3-cycle gaps (bit_valid=0) between bits -> data_out=8'h5D, with no word_valid until the 8th bit.
3. Two words back-to-back (8'hBA then 8'h3C), no idle cycle -> two word_valid pulses 8 cycles apart; data_out holds 8'hBA until the second completion.
4. Five bits accepted, then start=1 with bit_valid=1, data_in=1, then 7 more bits 0,0,1,1,1,1,0 -> no word_valid for the partial word; next word_valid gives data_out=8'h9E (MSB_FIRST=1).
5. Reset asserted after 4 bits -> all outputs 0 on the next cycle, and no word_valid; the next 8 bits form a clean word.
6. With SIPO_FRAMED_PARITY_EN: 8'hBA plus parity bit 1 -> word_valid=1, parity_err=0. Then 8'hBA plus parity bit 0 -> parity_err=1. Without the macro, parity_err stays 0 throughout.

Source files
------------

// File: rtl/sipo_framed.sv
// sipo_framed: parametrised serial-in/parallel-out deserialiser.
//
// Bits qualified by bit_valid are shifted into a WIDTH-bit register, either
// MSB-first (shift left) or LSB-first (shift right). When a word is complete,
// it is loaded into data_out. word_valid pulses for the one cycle that
// follows. start resynchronises the framer and drops any partial word.
//
// Optional feature, enabled by defining SIPO_FRAMED_PARITY_EN:
//   One extra even-parity bit follows each word. The word completes on the
//   parity bit's edge, and parity_err is registered together with data_out.
//   When the macro is undefined, parity_err is tied to 0.

module sipo_framed #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             bit_valid,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             word_valid,
    output logic [CW-1:0]    bit_count,
    output logic             busy,
    output logic             parity_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PAR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wv_q, wv_d;
`ifdef SIPO_FRAMED_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    // Candidate register values with the incoming bit shifted in: one continues
    // the current word, the other starts a fresh word from an empty register.
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;

    // Shift-order selection for continuing and for freshly started words.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[WIDTH-2:0], data_in};
            fresh   = {{(WIDTH-1){1'b0}}, data_in};
        end else begin
            shifted = {data_in, shift_q[WIDTH-1:1]};
            fresh   = {data_in, {(WIDTH-1){1'b0}}};
        end
    end

    // Next-state logic: start first, then accepted bits; idle cycles hold state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        data_d  = data_q;
        wv_d    = 1'b0;
`ifdef SIPO_FRAMED_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        if (start) begin
            state_d = ST_IDLE;
            shift_d = '0;
            count_d = '0;
`ifdef SIPO_FRAMED_PARITY_EN
            par_d   = 1'b0;
`endif
            if (bit_valid) begin
                state_d = ST_SHIFT;
                shift_d = fresh;
                count_d = CW'(1);
`ifdef SIPO_FRAMED_PARITY_EN
                par_d   = data_in;
`endif
            end
        end else if (bit_valid) begin
            case (state_q)
`ifdef SIPO_FRAMED_PARITY_EN
                ST_PAR: begin
                    data_d  = shift_q;
                    perr_d  = par_q ^ data_in;
                    wv_d    = 1'b1;
                    shift_d = '0;
                    par_d   = 1'b0;
                    state_d = ST_IDLE;
                end
`endif
                default: begin
                    if (count_q == CW'(WIDTH - 1)) begin
                        count_d = '0;
`ifdef SIPO_FRAMED_PARITY_EN
                        shift_d = shifted;
                        par_d   = par_q ^ data_in;
                        state_d = ST_PAR;
`else
                        data_d  = shifted;
                        wv_d    = 1'b1;
                        shift_d = '0;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        count_d = count_q + CW'(1);
                        shift_d = shifted;
                        state_d = ST_SHIFT;
`ifdef SIPO_FRAMED_PARITY_EN
                        par_d   = par_q ^ data_in;
`endif
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            wv_q    <= 1'b0;
`ifdef SIPO_FRAMED_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            data_q  <= data_d;
            wv_q    <= wv_d;
`ifdef SIPO_FRAMED_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign word_valid = wv_q;
    assign bit_count  = count_q;
    assign busy       = (count_q != '0) || (state_q == ST_PAR);
`ifdef SIPO_FRAMED_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_framed.sv
// tb_sipo_framed: directed self-checking bench for sipo_framed.
// Two instances share the stimulus: one MSB-first and one LSB-first (WIDTH=8).
// Builds with or without SIPO_FRAMED_PARITY_EN.

module tb_sipo_framed;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       start = 1'b0;

    logic [7:0] dout_m, dout_l;
    logic       wv_m, wv_l;
    logic [3:0] bc_m, bc_l;
    logic       busy_m, busy_l;
    logic       perr_m, perr_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_framed #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .data_in(data_in), .bit_valid(bit_valid), .start(start),
        .data_out(dout_m), .word_valid(wv_m), .bit_count(bc_m), .busy(busy_m),
        .parity_err(perr_m)
    );

    sipo_framed #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .data_in(data_in), .bit_valid(bit_valid), .start(start),
        .data_out(dout_l), .word_valid(wv_l), .bit_count(bc_l), .busy(busy_l),
        .parity_err(perr_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic tick(input logic bv, input logic d, input logic st);
        bit_valid = bv;
        data_in   = d;
        start     = st;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    function automatic logic perr_exp(input logic [7:0] w, input logic p);
`ifdef SIPO_FRAMED_PARITY_EN
        return (^w) ^ p;
`else
        return 1'b0;
`endif
    endfunction

    // Send a word as w[7] first. In parity builds the parity bit p follows.
    // 'gap' idle cycles with X data separate the data bits. 'hold' is the
    // data_out value expected while the word is in flight.
    task automatic send_word(input logic [7:0] w, input logic p, input int gap,
                             input logic [7:0] hold);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, w[7-i], 1'b0);
            if (i < 7) begin
                check("sw_count", 32'(bc_m), 32'(i + 1));
                check("sw_wv", 32'(wv_m), 32'd0);
                check("sw_busy", 32'(busy_m), 32'd1);
                check("sw_hold", 32'(dout_m), 32'(hold));
                for (int g = 0; g < gap; g++) begin
                    tick(1'b0, 1'bx, 1'b0);
                    check("gap_count", 32'(bc_m), 32'(i + 1));
                    check("gap_wv", 32'(wv_l), 32'd0);
                end
            end
        end
`ifdef SIPO_FRAMED_PARITY_EN
        check("par_count", 32'(bc_m), 32'd0);
        check("par_busy", 32'(busy_m), 32'd1);
        check("par_wv", 32'(wv_m), 32'd0);
        tick(1'b1, p, 1'b0);
`endif
    endtask

    // Check a completed word on both instances.
    task automatic check_done(input string tag, input logic [7:0] w, input logic p);
        check({tag, "_wv_m"}, 32'(wv_m), 32'd1);
        check({tag, "_wv_l"}, 32'(wv_l), 32'd1);
        check({tag, "_dout_m"}, 32'(dout_m), 32'(w));
        check({tag, "_dout_l"}, 32'(dout_l), 32'(rev8(w)));
        check({tag, "_count"}, 32'(bc_m), 32'd0);
        check({tag, "_busy"}, 32'(busy_m), 32'd0);
        check({tag, "_perr_m"}, 32'(perr_m), 32'(perr_exp(w, p)));
        check({tag, "_perr_l"}, 32'(perr_l), 32'(perr_exp(w, p)));
    endtask

    initial begin
        logic [6:0] tail;

        // Reset for two cycles.
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("rst_dout_m", 32'(dout_m), 32'd0);
        check("rst_dout_l", 32'(dout_l), 32'd0);
        check("rst_wv", 32'(wv_m), 32'd0);
        check("rst_count", 32'(bc_m), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_perr", 32'(perr_m), 32'd0);
        reset = 1'b0;

        // 1: 8'hBA on consecutive cycles, then a one-cycle word_valid.
        send_word(8'hBA, 1'b1, 0, 8'h00);
        check_done("t1", 8'hBA, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("t1_pulse_end", 32'(wv_m), 32'd0);
        check("t1_held", 32'(dout_m), 32'hBA);

        // 2: the same bits with 3-cycle gaps; the LSB-first copy yields 8'h5D.
        send_word(8'hBA, 1'b1, 3, 8'hBA);
        check_done("t2", 8'hBA, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // 3: back-to-back words; the second word's first bit lands in the valid cycle.
        send_word(8'hBA, 1'b1, 0, 8'hBA);
        check_done("t3a", 8'hBA, 1'b1);
        send_word(8'h3C, 1'b0, 0, 8'hBA);
        check_done("t3b", 8'h3C, 1'b0);

        // 4: five bits, then start together with a bit, then seven more bits -> 8'h9E.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
        check("t4_partial", 32'(bc_m), 32'd5);
        tick(1'b1, 1'b1, 1'b1);
        check("t4_restart_cnt", 32'(bc_m), 32'd1);
        check("t4_restart_wv", 32'(wv_m), 32'd0);
        check("t4_restart_dout", 32'(dout_m), 32'h3C);
        tail = 7'b0011110;
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, tail[6-i], 1'b0);
            if (i < 6) check("t4_wv_low", 32'(wv_m), 32'd0);
        end
`ifdef SIPO_FRAMED_PARITY_EN
        check("t4_par_busy", 32'(busy_m), 32'd1);
        tick(1'b1, 1'b1, 1'b0);
`endif
        check_done("t4", 8'h9E, 1'b1);

        // Start alone mid-word: the partial word is dropped and data_out is kept.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("st_count", 32'(bc_m), 32'd0);
        check("st_busy", 32'(busy_m), 32'd0);
        check("st_wv", 32'(wv_m), 32'd0);
        check("st_dout", 32'(dout_m), 32'h9E);

        // Start on the final data bit: start wins, and the bit opens a new word (8'h61).
        tail = 7'b1011101;
        for (int i = 0; i < 7; i++) tick(1'b1, tail[6-i], 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("sf_count", 32'(bc_m), 32'd1);
        check("sf_wv", 32'(wv_m), 32'd0);
        check("sf_dout", 32'(dout_m), 32'h9E);
        tail = 7'b1100001;
        for (int i = 0; i < 7; i++) tick(1'b1, tail[6-i], 1'b0);
`ifdef SIPO_FRAMED_PARITY_EN
        tick(1'b1, 1'b1, 1'b0);
`endif
        check_done("sf", 8'h61, 1'b1);

        // 5: reset after four bits beats start and bit_valid; a clean word follows.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b1);
        check("t5_dout_m", 32'(dout_m), 32'd0);
        check("t5_dout_l", 32'(dout_l), 32'd0);
        check("t5_wv", 32'(wv_m), 32'd0);
        check("t5_count", 32'(bc_m), 32'd0);
        check("t5_busy", 32'(busy_m), 32'd0);
        check("t5_perr", 32'(perr_m), 32'd0);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        check("t5_no_word", 32'(wv_m), 32'd0);
        send_word(8'hA5, 1'b0, 0, 8'h00);
        check_done("t5", 8'hA5, 1'b0);

        // 6: 8'hBA with a wrong parity bit. parity_err is 1 only when parity is compiled in.
        send_word(8'hBA, 1'b0, 0, 8'hA5);
        check_done("t6", 8'hBA, 1'b0);

        tick(1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
